hidden_weight_fetch: RTL
========================

Name: hidden_weight_fetch

Overview:
- Read-side sequencer for the hidden-layer weight ROM (synchronous, 1-cycle read latency, 15-bit address, 8-bit data).
- Walks the ROM neuron-major: addr = neuron*N_IN + input.
- Streams each weight to the hidden-layer MAC over a valid/ready interface, tagged with neuron and input indices.
- A 2-entry skid FIFO absorbs ROM latency under MAC backpressure.

Parameters:
- N_IN, 784, inputs per hidden neuron.
- N_HID, 32, hidden neurons.
- ADDR_W, 15, ROM address width; must satisfy N_IN*N_HID <= 2**ADDR_W.
- DATA_W, 8, weight width; matches the MAC.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, begin one full pass; sampled only in IDLE.
- busy, output, 1, high from the cycle after start is accepted until done.
- done, output, 1, one-cycle pulse after the final beat handshakes.
- rom_addr, output, ADDR_W, registered address to the ROM.
- rom_q, input, DATA_W, ROM data, valid the cycle after rom_addr is presented.
- w_valid, output, 1, weight beat available.
- w_ready, input, 1, MAC accepts the beat.
- w_data, output, DATA_W, weight.
- w_neuron, output, 5, neuron index of the beat.
- w_in_idx, output, 10, input index of the beat.
- w_last, output, 1, w_in_idx == N_IN-1.
- w_final, output, 1, last beat of the pass (neuron N_HID-1, input N_IN-1).

Behaviour:
- Reset values: busy=0, done=0, rom_addr=0, w_valid=0, w_data=0, w_neuron=0, w_in_idx=0, w_last=0, w_final=0.
- Reset also empties the FIFO, clears the in-flight flag, and forces IDLE.
- Reset mid-pass aborts the pass: no done, and no further beats appear.
- FSM states:
  - IDLE: start=1 -> FETCH. rom_addr=0, issue counters cleared, busy=1 next cycle.
  - FETCH: issue addresses. After the address N_IN*N_HID-1 is issued -> DRAIN.
  - DRAIN: no new issues. When the FIFO is empty, nothing is in flight, and the final beat has handshaked -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- start outside IDLE is ignored.
- Issue rule: a ROM read is issued in a cycle when FETCH && (fifo_count + inflight − pop) < 2, where pop = w_valid && w_ready.
- An issue sets the inflight flag for the next cycle. In that next cycle, rom_q is written into the FIFO tail together with its neuron and input tags.
- rom_addr advances by 1 only on an issue and otherwise holds. It is a running counter; no multiplier is used.
- Tag counters: in_idx wraps N_IN-1 -> 0 and increments neuron on wrap.
- w_* outputs come from the FIFO head register. w_valid = (fifo_count != 0).
- Beat stability: while w_valid && !w_ready, all w_* outputs hold stable.
- Simultaneous push and pop at count 1 or 2 leaves the count unchanged.
- The FIFO never overflows; the issue rule guarantees this. An overflow is a bench assertion failure.
- Latency: start sampled at cycle S -> rom_addr=0 in S+1 -> FIFO write at the end of S+2 -> first w_valid in S+3.
- With w_ready held at 1: one beat per cycle, beat k in S+3+k, final beat in S+25090, done in S+25091.
- Beats are delivered in strict address order, with no drops or duplicates under any w_ready pattern.

Optional Feature:
- Macro: HIDDEN_WEIGHT_FETCH_CHECKSUM_EN.
- Defined:
  - Adds output port checksum[15:0].
  - checksum is cleared on start acceptance, and on reset.
  - Each handshaked beat adds w_data, zero-extended, modulo 2^16.
  - The value is held after done until the next start.
- Undefined: no port and no accumulator logic; all other behaviour is identical.

Test Plan:
- ROM loaded with rom[a]=a[7:0], w_ready=1, start pulse at cycle S:
  - first w_valid in S+3, w_data=0x00.
  - 25088 beats, w_data = index mod 256.
  - w_last on every w_in_idx=783.
  - w_final on beat 25087 (neuron 31).
  - done in S+25091, busy low afterwards.
- Random w_ready (50%), same ROM:
  - beat sequence identical to the previous run.
  - w_* stable while stalled.
  - FIFO count never exceeds 2.
- w_ready held 0 for 20 cycles after start:
  - exactly beat 0 is visible and held.
  - rom_addr stops at 2, with at most 2 entries buffered.
  - on release, beats 0,1,2,... continue with no gaps.
- start re-pulsed at beat 100 while busy -> ignored; pass completes with 25088 beats and a single done.
- rst asserted at beat 500 for 1 cycle:
  - all outputs at reset values the next cycle; no done.
  - a fresh start produces a full pass beginning at beat 0.
- With HIDDEN_WEIGHT_FETCH_CHECKSUM_EN and the same ROM: checksum = 0xCF00 when done pulses.

Source files
------------

// File: rtl/hidden_weight_fetch_if.sv
// Weight-beat stream from the hidden-layer weight fetch sequencer to the MAC.
interface hidden_weight_fetch_if #(
  parameter int DATA_W = 8
) ();
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic [4:0]        w_neuron;
  logic [9:0]        w_in_idx;
  logic              w_last;
  logic              w_final;

  modport master (
    output w_valid, w_data, w_neuron, w_in_idx, w_last, w_final,
    input  w_ready
  );

  modport slave (
    input  w_valid, w_data, w_neuron, w_in_idx, w_last, w_final,
    output w_ready
  );
endinterface

// File: rtl/hidden_weight_fetch.sv
// Neuron-major read sequencer for the hidden-layer weight ROM with a 2-entry skid FIFO.
// Optional 16-bit beat checksum output enabled by HIDDEN_WEIGHT_FETCH_CHECKSUM_EN.
module hidden_weight_fetch #(
  parameter int N_IN   = 784,
  parameter int N_HID  = 32,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  hidden_weight_fetch_if.master w
`ifdef HIDDEN_WEIGHT_FETCH_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN * N_HID - 1);
  localparam logic [9:0]        IN_LAST   = 10'(N_IN - 1);
  localparam logic [4:0]        HID_LAST  = 5'(N_HID - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [4:0]        neuron;
    logic [9:0]        in_idx;
    logic              last;
    logic              fin;
  } entry_t;

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [9:0]        in_cnt_q, in_cnt_d;
  logic [4:0]        neu_cnt_q, neu_cnt_d;
  logic              inflight_q, inflight_d;
  logic [9:0]        pend_in_q, pend_in_d;
  logic [4:0]        pend_neu_q, pend_neu_d;
  logic [1:0]        count_q, count_d;
  entry_t            head_q, head_d;
  entry_t            tail_q, tail_d;
  logic              valid_q, valid_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;
  entry_t            push_entry;

  // Issue decision, tag counters, skid FIFO and pass-level FSM.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rom_addr_d = rom_addr_q;
    in_cnt_d   = in_cnt_q;
    neu_cnt_d  = neu_cnt_q;
    inflight_d = 1'b0;
    pend_in_d  = pend_in_q;
    pend_neu_d = pend_neu_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;

    pop  = valid_q && w.w_ready;
    push = inflight_q;
    push_entry.data   = rom_q;
    push_entry.neuron = pend_neu_q;
    push_entry.in_idx = pend_in_q;
    push_entry.last   = (pend_in_q == IN_LAST);
    push_entry.fin    = (pend_in_q == IN_LAST) && (pend_neu_q == HID_LAST);

    // Slots already claimed after this cycle's pop; a read may only be issued if one is free.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == S_FETCH) && (occupancy < 3'd2);

    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = push_entry;
        end else begin
          tail_d = push_entry;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end else begin
          head_d = head_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd2) begin
          head_d = tail_q;
          tail_d = push_entry;
        end else begin
          head_d = push_entry;
        end
      end
      default: count_d = count_q;
    endcase
    valid_d = (count_d != 2'd0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          busy_d     = 1'b1;
          rom_addr_d = '0;
          in_cnt_d   = 10'd0;
          neu_cnt_d  = 5'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (issue && (rom_addr_q == LAST_ADDR)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if ((count_d == 2'd0) && !inflight_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (issue) begin
      rom_addr_d = rom_addr_q + ADDR_W'(1);
      inflight_d = 1'b1;
      pend_in_d  = in_cnt_q;
      pend_neu_d = neu_cnt_q;
      if (in_cnt_q == IN_LAST) begin
        in_cnt_d  = 10'd0;
        neu_cnt_d = neu_cnt_q + 5'd1;
      end else begin
        in_cnt_d  = in_cnt_q + 10'd1;
      end
    end else begin
      inflight_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      in_cnt_q   <= 10'd0;
      neu_cnt_q  <= 5'd0;
      inflight_q <= 1'b0;
      pend_in_q  <= 10'd0;
      pend_neu_q <= 5'd0;
      count_q    <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_addr_q <= rom_addr_d;
      in_cnt_q   <= in_cnt_d;
      neu_cnt_q  <= neu_cnt_d;
      inflight_q <= inflight_d;
      pend_in_q  <= pend_in_d;
      pend_neu_q <= pend_neu_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_addr   = rom_addr_q;
  assign w.w_valid  = valid_q;
  assign w.w_data   = head_q.data;
  assign w.w_neuron = head_q.neuron;
  assign w.w_in_idx = head_q.in_idx;
  assign w.w_last   = head_q.last;
  assign w.w_final  = head_q.fin;

`ifdef HIDDEN_WEIGHT_FETCH_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Running sum of handshaked beats, restarted when a pass is accepted.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == S_IDLE) && start) begin
      checksum_d = 16'd0;
    end else if (pop) begin
      checksum_d = checksum_q + 16'(head_q.data);
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= 16'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
